// File: rtl/stack_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_exec_pkg
// Description : Opcodes, FSM states, error codes and op-class decode for the
//               stack execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_exec_pkg;

    localparam logic [4:0] c_op_nop  = 5'b00000;
    localparam logic [4:0] c_op_push = 5'b00001;
    localparam logic [4:0] c_op_pop  = 5'b00010;
    localparam logic [4:0] c_op_dup  = 5'b00011;
    localparam logic [4:0] c_op_swap = 5'b00100;
    localparam logic [4:0] c_op_add  = 5'b01000;
    localparam logic [4:0] c_op_sub  = 5'b01001;
    localparam logic [4:0] c_op_and  = 5'b01010;
    localparam logic [4:0] c_op_or   = 5'b01011;
    localparam logic [4:0] c_op_xor  = 5'b01100;
    localparam logic [4:0] c_op_mul  = 5'b01101;
    localparam logic [4:0] c_op_eq   = 5'b01110;
    localparam logic [4:0] c_op_lt   = 5'b01111;
    localparam logic [4:0] c_op_not  = 5'b10000;
    localparam logic [4:0] c_op_neg  = 5'b10001;

    localparam logic [1:0] c_err_none    = 2'b00;
    localparam logic [1:0] c_err_under   = 2'b01;
    localparam logic [1:0] c_err_over    = 2'b10;
    localparam logic [1:0] c_err_illegal = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP_A  = 3'd1,
        POP_B  = 3'd2,
        EXEC   = 3'd3,
        PUSH_R = 3'd4,
        PUSH_S = 3'd5
    } state_t;

    // grows marks ops whose net effect is one extra entry (PUSH, DUP)
    typedef struct packed {
        logic       legal;
        logic [1:0] pops;
        logic       exec;
        logic [1:0] pushes;
        logic       grows;
    } op_class_t;

    function automatic op_class_t op_decode(input logic [4:0] op);
        op_class_t c;
        c       = '0;
        c.legal = 1'b1;
        case (op)
            c_op_nop:  c.exec = 1'b1;
            c_op_push: begin c.pushes = 2'd1; c.grows = 1'b1; end
            c_op_pop:  c.pops = 2'd1;
            c_op_dup:  begin c.pops = 2'd1; c.pushes = 2'd2; c.grows = 1'b1; end
            c_op_swap: begin c.pops = 2'd2; c.pushes = 2'd2; end
            c_op_not, c_op_neg: begin
                c.pops = 2'd1; c.exec = 1'b1; c.pushes = 2'd1;
            end
            c_op_add, c_op_sub, c_op_and, c_op_or,
            c_op_xor, c_op_mul, c_op_eq, c_op_lt: begin
                c.pops = 2'd2; c.exec = 1'b1; c.pushes = 2'd1;
            end
            default:   c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_exec_alu.sv
`default_nettype none
// ============================================================================
// Module      : stack_exec_alu
// Description : Combinational ALU; X is second-from-top, Y is the popped top.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_exec_alu
    import stack_exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R,
    output logic             cmp
);

    always_comb begin
        R   = '0;
        cmp = 1'b0;
        case (op)
            c_op_add: R = X + Y;
            c_op_sub: R = X - Y;
            c_op_and: R = X & Y;
            c_op_or:  R = X | Y;
            c_op_xor: R = X ^ Y;
            c_op_mul: R = X * Y;
            c_op_eq: begin
                cmp = (X == Y);
                R   = {{(WIDTH-1){1'b0}}, cmp};
            end
            c_op_lt: begin
                cmp = (X < Y);
                R   = {{(WIDTH-1){1'b0}}, cmp};
            end
            c_op_not: R = ~Y;
            c_op_neg: R = -Y;
            default:  R = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stack_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : stack_exec_unit
// Description : Stack machine executing one command as a short sequence of
//               pop / exec / push states over a register-file stack.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_exec_unit
    import stack_exec_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             flag,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int            c_aw   = $clog2(DEPTH);
    localparam logic [CW-1:0] c_one  = CW'(1);
    localparam logic [CW-1:0] c_two  = CW'(2);
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a, r_b, r_r, r_s;
    logic [4:0]       r_op;
    logic [1:0]       r_pops, r_pushes;
    logic             r_exec;
    logic             r_flag, r_done, r_err;
    logic [1:0]       r_err_code;

    op_class_t        w_cls;
    logic             w_accept, w_under, w_over, w_reject, w_seq_end, w_push;
    logic [1:0]       w_code;
    logic [CW-1:0]    w_cnt_m1;
    logic [WIDTH-1:0] w_tos, w_alu_r;
    logic             w_alu_cmp;

    assign cmd_ready = (r_state == IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_cls     = op_decode(cmd_op);
    assign w_cnt_m1  = r_count - c_one;
    assign w_tos     = r_mem[w_cnt_m1[c_aw-1:0]];
    assign top       = (r_count == '0) ? '0 : w_tos;

    // Legality is judged against the count at acceptance only
    assign w_under = (w_cls.pops == 2'd2) ? (r_count < c_two) :
                     (w_cls.pops == 2'd1) ? (r_count == '0) : 1'b0;
    assign w_over  = w_cls.grows && (r_count == c_full);

    always_comb begin
        w_code = c_err_none;
        if (!w_cls.legal)  w_code = c_err_illegal;
        else if (w_under)  w_code = c_err_under;
        else if (w_over)   w_code = c_err_over;
    end
    assign w_reject = (w_code != c_err_none);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_reject) begin
                    if (w_cls.pops != 2'd0)        w_next = POP_A;
                    else if (w_cls.exec)           w_next = EXEC;
                    else if (w_cls.pushes != 2'd0) w_next = PUSH_R;
                end
            end
            POP_A: begin
                if (r_pops == 2'd2)                w_next = POP_B;
                else if (r_exec)                   w_next = EXEC;
                else if (r_pushes != 2'd0)         w_next = PUSH_R;
                else                               w_next = IDLE;
            end
            POP_B: begin
                if (r_exec)                        w_next = EXEC;
                else if (r_pushes != 2'd0)         w_next = PUSH_R;
                else                               w_next = IDLE;
            end
            EXEC:   w_next = (r_pushes != 2'd0) ? PUSH_R : IDLE;
            PUSH_R: w_next = (r_pushes == 2'd2) ? PUSH_S : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_seq_end = (r_state != IDLE) && (w_next == IDLE);

    stack_exec_alu #(.WIDTH(WIDTH)) u_alu (
        .op  (r_op),
        .X   (r_b),
        .Y   (r_a),
        .R   (w_alu_r),
        .cmp (w_alu_cmp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_r        <= '0;
            r_s        <= '0;
            r_op       <= c_op_nop;
            r_pops     <= 2'd0;
            r_pushes   <= 2'd0;
            r_exec     <= 1'b0;
            r_flag     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= c_err_none;
        end else begin
            r_state <= w_next;
            r_done  <= w_seq_end || (w_accept && w_reject);
            r_err   <= w_accept && w_reject;
            if (w_accept) begin
                r_op       <= cmd_op;
                r_pops     <= w_cls.pops;
                r_pushes   <= w_cls.pushes;
                r_exec     <= w_cls.exec;
                r_err_code <= w_code;
                if (!w_reject && cmd_op == c_op_push) r_r <= cmd_imm;
            end
            // R/S for DUP and SWAP are staged while popping
            case (r_state)
                POP_A: begin
                    r_a     <= w_tos;
                    r_count <= w_cnt_m1;
                    if (r_op == c_op_dup) begin
                        r_r <= w_tos;
                        r_s <= w_tos;
                    end
                end
                POP_B: begin
                    r_b     <= w_tos;
                    r_count <= w_cnt_m1;
                    if (r_op == c_op_swap) begin
                        r_r <= r_a;
                        r_s <= w_tos;
                    end
                end
                EXEC: begin
                    r_r <= w_alu_r;
                    if (r_op == c_op_eq || r_op == c_op_lt) r_flag <= w_alu_cmp;
                end
                PUSH_R, PUSH_S: r_count <= r_count + c_one;
                default: ;
            endcase
        end
    end

    assign w_push = (r_state == PUSH_R) || (r_state == PUSH_S);

    always_ff @(posedge clk) begin
        if (!reset && w_push)
            r_mem[r_count[c_aw-1:0]] <= (r_state == PUSH_S) ? r_s : r_r;
    end

    assign count    = r_count;
    assign flag     = r_flag;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_stack_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_exec_unit
// Description : Scoreboard bench with a queue-based stack reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stack_exec_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [4:0] c_nop = 5'b00000, c_push = 5'b00001, c_pop = 5'b00010,
                           c_dup = 5'b00011, c_swap = 5'b00100, c_add = 5'b01000,
                           c_sub = 5'b01001, c_and = 5'b01010, c_or  = 5'b01011,
                           c_xor = 5'b01100, c_mul = 5'b01101, c_eq  = 5'b01110,
                           c_lt  = 5'b01111, c_not = 5'b10000, c_neg = 5'b10001;

    logic             clk = 1'b0;
    logic             reset, cmd_valid, cmd_ready, flag, done, err;
    logic [4:0]       cmd_op;
    logic [WIDTH-1:0] cmd_imm, top;
    logic [CW-1:0]    count;
    logic [1:0]       err_code;

    stack_exec_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_imm(cmd_imm), .top(top), .count(count),
        .flag(flag), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic             err;
        logic [1:0]       code;
        logic [WIDTH-1:0] top;
        int               cnt;
        logic             flag;
        int               lat;
        int               acc;
    } exp_t;

    exp_t             q[$];
    logic [WIDTH-1:0] stk[$];
    logic             m_flag;
    logic [4:0]       ops [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: stack as a queue, rules applied directly to whole commands
    task automatic model(input logic [4:0] op, input logic [WIDTH-1:0] imm, output exp_t e);
        int need, nst;
        bit grows, bad;
        logic [WIDTH-1:0] a, b, res;
        need = 0; nst = 0; grows = 0; bad = 0; res = '0;
        case (op)
            c_nop:  nst = 1;
            c_push: begin grows = 1; nst = 1; end
            c_pop:  begin need = 1; nst = 1; end
            c_dup:  begin need = 1; grows = 1; nst = 3; end
            c_swap: begin need = 2; nst = 4; end
            c_not, c_neg: begin need = 1; nst = 3; end
            c_add, c_sub, c_and, c_or, c_xor, c_mul, c_eq, c_lt: begin need = 2; nst = 4; end
            default: bad = 1;
        endcase
        e.err = 1'b1;
        e.lat = 1;
        if (bad)                                   e.code = 2'b11;
        else if (stk.size() < need)                e.code = 2'b01;
        else if (grows && stk.size() >= DEPTH)     e.code = 2'b10;
        else begin
            e.err  = 1'b0;
            e.code = 2'b00;
            e.lat  = nst + 1;
            case (op)
                c_nop:  ;
                c_push: stk.push_back(imm);
                c_pop:  void'(stk.pop_back());
                c_dup:  stk.push_back(stk[$]);
                c_swap: begin
                    a = stk.pop_back(); b = stk.pop_back();
                    stk.push_back(a); stk.push_back(b);
                end
                c_not: begin a = stk.pop_back(); res = ~a; stk.push_back(res); end
                c_neg: begin a = stk.pop_back(); res = 16'd0 - a; stk.push_back(res); end
                default: begin
                    a = stk.pop_back();
                    b = stk.pop_back();
                    case (op)
                        c_add: res = b + a;
                        c_sub: res = b - a;
                        c_and: res = b & a;
                        c_or:  res = b | a;
                        c_xor: res = b ^ a;
                        c_mul: res = b * a;
                        c_eq:  begin res = (b == a) ? 16'd1 : 16'd0; m_flag = res[0]; end
                        default: begin res = (b < a) ? 16'd1 : 16'd0; m_flag = res[0]; end
                    endcase
                    stk.push_back(res);
                end
            endcase
        end
        e.cnt  = stk.size();
        e.top  = (stk.size() > 0) ? stk[$] : '0;
        e.flag = m_flag;
        e.acc  = 0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [WIDTH-1:0] imm);
        exp_t e;
        bit   got;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1; break; end
        end
        if (!got) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
        model(op, imm, e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q.size() == 0 && cmd_ready && !done) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        stk.delete(); q.delete(); m_flag = 1'b0;
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("err",      err,      e.err);
                    chk("err_code", err_code, e.code);
                    chk("top",      top,      e.top);
                    chk("count",    count,    e.cnt);
                    chk("flag",     flag,     e.flag);
                    chk("latency",  cyc - e.acc + 1, e.lat);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r;
        bit  bad_seen;
        logic [4:0] op;
        ops = '{c_nop, c_pop, c_dup, c_swap, c_add, c_sub, c_and, c_or,
                c_xor, c_mul, c_eq, c_lt, c_not, c_neg, c_push};
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_imm = '0; m_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_top", top, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_flag", flag, 0);

        issue(c_push, 16'd5); issue(c_push, 16'd3); issue(c_sub, '0); drain();
        chk("sub_top", top, 16'd2);
        chk("sub_count", count, 1);

        issue(c_push, 16'd3); issue(c_push, 16'd5); issue(c_lt, '0); drain();
        chk("lt_top", top, 16'd1);
        chk("lt_flag", flag, 1);
        issue(c_push, 16'd9); issue(c_push, 16'd9); issue(c_eq, '0);
        issue(c_not, '0); drain();
        chk("eq_flag", flag, 1);
        chk("not_top", top, 16'hFFFE);

        issue(c_push, 16'hFFFF); issue(c_push, 16'h0002); issue(c_add, '0); drain();
        chk("add_wrap_top", top, 16'h0001);
        issue(c_push, 16'h00FF); issue(c_push, 16'h0100); issue(c_mul, '0); drain();
        chk("mul_top", top, 16'hFF00);

        do_reset();
        issue(c_pop, '0); issue(c_push, 16'h1234); issue(c_add, '0);
        issue(5'b10010, '0); drain();
        chk("illegal_code_held", err_code, 2'b11);
        chk("illegal_count", count, 1);

        do_reset();
        for (int i = 1; i <= DEPTH; i++) issue(c_push, 16'(i));
        issue(c_push, 16'hAAAA); issue(c_dup, '0); drain();
        chk("full_code", err_code, 2'b10);
        chk("full_count", count, DEPTH);
        issue(c_swap, '0); drain();
        chk("swap_top", top, DEPTH - 1);
        chk("swap_clears_code", err_code, 2'b00);
        issue(c_pop, '0); drain();
        chk("pop_top", top, DEPTH);

        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      op = c_push;
            else if (r < 38) op = 5'($urandom_range(0, 31));
            else             op = ops[$urandom_range(0, 13)];
            issue(op, 16'($urandom));
        end
        drain();

        do_reset();
        issue(c_push, 16'd7); issue(c_push, 16'd7); issue(c_eq, '0);
        issue(c_push, 16'd1); issue(c_push, 16'd2); issue(c_push, 16'd3); drain();
        chk("pre_rst_count", count, 4);
        chk("pre_rst_flag", flag, 1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = c_add; cmd_imm = '0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        stk.delete(); q.delete(); m_flag = 1'b0;
        @(negedge clk);
        chk("midrst_count", count, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_flag", flag, 0);
        chk("midrst_top", top, 0);
        bad_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (count != 0 || done) bad_seen = 1;
        end
        chk("midrst_no_push", bad_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_exec_unit.md
STACK_EXEC_UNIT -- requirements
Module: stack_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter DEPTH, default 16, stack entries (power of two, at least 4).
REQ-003 SHALL have parameter CW, default $clog2(DEPTH+1), width of the count output.
REQ-004 SHALL use one clock and a synchronous, active-high reset. All state changes on the rising edge of clk; reset is sampled on that edge.
REQ-005 SHALL provide these ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit idle; accepts the command this cycle.
- cmd_op  in  5  opcode.
- cmd_imm  in  WIDTH  immediate for PUSH.
- top  out  WIDTH  current top-of-stack.
- count  out  CW  occupied entries.
- flag  out  1  last compare result.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle rejection pulse (with done).
- err_code  out  2  last error: 00 none, 01 underflow, 10 overflow, 11 illegal opcode.

Function
REQ-006 Handshake: a command SHALL be accepted on an edge where cmd_valid and cmd_ready are both high. cmd_ready SHALL be high only in IDLE. cmd_op and cmd_imm SHALL be captured at acceptance.
REQ-007 FSM states SHALL be: IDLE, POP_A, POP_B, EXEC, PUSH_R, PUSH_S. Each non-IDLE state lasts one cycle.
REQ-008 POP_A SHALL load A from entry count-1 and decrement count. POP_B SHALL do the same into B. PUSH_R SHALL write R at entry count and increment count. PUSH_S SHALL do the same with S.
REQ-009 Opcodes and their state sequences SHALL be:
- 00000 NOP: EXEC.
- 00001 PUSH: PUSH_R, with R=imm.
- 00010 POP: POP_A.
- 00011 DUP: POP_A, PUSH_R, PUSH_S, with R=S=A.
- 00100 SWAP: POP_A, POP_B, PUSH_R, PUSH_S, with R=A and S=B.
- 10000 NOT and 10001 NEG: POP_A, EXEC, PUSH_R.
- 01000 ADD, 01001 SUB, 01010 AND, 01011 OR, 01100 XOR, 01101 MUL, 01110 EQ, 01111 LT: POP_A, POP_B, EXEC, PUSH_R.
- Every other opcode is illegal.
REQ-010 ALU operands SHALL be X=B (second from top) and Y=A (popped top). Result R is computed in EXEC and registered.
- SUB = X-Y.
- MUL = low WIDTH bits of X*Y.
- ADD, SUB and NEG wrap modulo 2^WIDTH.
- LT is unsigned.
REQ-011 EQ and LT SHALL push R = {WIDTH-1 zeros, result} and load flag with the result. All other operations SHALL leave flag unchanged.
REQ-012 done SHALL be high for exactly the first IDLE cycle after a sequence ends. A new command MAY be accepted in that same cycle.
REQ-013 Legality SHALL be checked at acceptance, against the count at acceptance:
- POP, DUP, NOT and NEG need count>=1.
- Binary ops and SWAP need count>=2.
- PUSH needs count<DEPTH.
- DUP needs count<DEPTH.
REQ-014 On a rejected command, stack, count and flag SHALL stay unchanged. done and err SHALL both be high in the cycle after acceptance. err_code SHALL be set to the matching code; illegal opcode takes priority over underflow, which takes priority over overflow.
REQ-015 err_code SHALL hold until the next accepted command. A successful command SHALL clear it to 00.
REQ-016 top SHALL combinationally show entry count-1 when count>0, and 0 when count==0.
REQ-017 count SHALL never exceed DEPTH and never go below 0. This is guaranteed by REQ-013 and needs no wrap logic.

Reset
REQ-018 Reset SHALL override everything, including mid-sequence. Next state is IDLE.
REQ-019 Reset values SHALL be: count 0, A/B/R/S 0, flag 0, done 0, err 0, err_code 00, cmd_ready 1 after the reset edge. Storage contents need not be cleared.

Structure
REQ-020 Package stack_exec_pkg SHALL hold: opcode localparams, the FSM state enum, err_code constants, and an op-class decode function giving needed pops and pushes.
REQ-021 The ALU SHALL be a combinational sub-module stack_exec_alu, parameterised by WIDTH, with inputs op, X, Y and outputs R, cmp. Stack storage and the FSM SHALL live in stack_exec_unit.

Verification
REQ-022 After reset: PUSH 5, then PUSH 3, then SUB. Required: SUB done 5 cycles after its accept edge; top=2; count=1; err=0.
REQ-023 PUSH 3, then PUSH 5, then LT. Required: top=1 and flag=1. Then PUSH 9, PUSH 9, EQ gives flag=1; then NOT gives top=0xFFFE.
REQ-024 Push 0xFFFF and 0x0002, then ADD, giving top=0x0001. Then push 0x00FF and 0x0100, then MUL, giving top=0xFF00. Wrap is verified for WIDTH=16.
REQ-025 Empty stack: POP, then ADD with count=1, then opcode 10010. Required: err_code 01, 01, 11 respectively, done=err=1 each time, count unchanged.
REQ-026 DEPTH pushes of 1..DEPTH, then PUSH and DUP both give err_code 10. SWAP then gives top=DEPTH-1; POP gives top=DEPTH.
REQ-027 Assert reset during POP_B of an ADD with count=4. Required: next cycle count=0, cmd_ready=1, done=0, flag=0, and no spurious push.
